control_seq: RTL
================

CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction/IR width (min 32).
REQ-002 SHALL have parameter SEL_WIDTH, default 4, register-file select width.
REQ-003 SHALL have parameter WAIT_LIMIT, default 15, max cycles waiting on mem_ready (1..255).
REQ-004 SHALL have ports, one clock; reset asynchronous, active-low:
  clk  in  1  clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  ir  in  DATA_WIDTH  current instruction
  status  in  4  flags {V,N,C,Z} = status[3:0]
  mem_ready  in  1  memory completes read/write this cycle
  mem_rd, mem_wr  out  1  memory strobes
  oe_a_reg_file, oe_b_reg_file, ld_reg_file  out  1  register-file controls
  sel_a_reg_file, sel_b_reg_file  out  SEL_WIDTH  register selects
  ld_ir, ld_status, oe_mar, ld_mar, oe_b_pc, ld_pc, inc_pc, oe_alu  out  1  datapath strobes
  alu_op  out  4  ALU operation
  halted  out  1  HALT state reached
  fault  out  1  FAULT state reached (sticky)

Function
REQ-005 SHALL decode ir[31:28]=cond, ir[27:24]=opcode, ir[23:20]=alu_op, ir[2*SEL_WIDTH-1:SEL_WIDTH]=sel_a, ir[SEL_WIDTH-1:0]=sel_b.
REQ-006 SHALL implement states FETCH, DECODE, EXEC, MEM, HALT, FAULT; registered state, outputs combinational from state/ir/mem_ready; every output 0 unless listed.
REQ-007 FETCH: oe_b_pc=1, mem_rd=1; in cycle mem_ready=1 also ld_ir=1, inc_pc=1, next DECODE.
REQ-008 DECODE: no strobes; one cycle; next EXEC if condition passes, else FETCH (instruction skipped, PC already incremented).
REQ-009 EXEC opcode 0 NOP: next FETCH.
REQ-010 EXEC opcode 1 ALU: oe_a_reg_file, oe_b_reg_file, oe_alu, ld_reg_file, ld_status=1, selects and alu_op from ir; next FETCH.
REQ-011 EXEC opcode 2 LD / 3 ST: oe_a_reg_file=1, ld_mar=1, sel_a from ir; next MEM.
REQ-012 MEM: oe_mar=1; LD: mem_rd=1 and, when mem_ready, ld_reg_file=1 with sel_b from ir; ST: mem_wr=1, oe_b_reg_file=1; next FETCH on mem_ready.
REQ-013 EXEC opcode 4 JMP: oe_a_reg_file=1, ld_pc=1; next FETCH.
REQ-014 EXEC opcode 15 HALT: next HALT; HALT is absorbing, halted=1.
REQ-015 EXEC any other opcode: next FAULT (illegal instruction).
REQ-016 Wait counter SHALL clear on entry to FETCH/MEM and increment each cycle mem_ready=0; reaching WAIT_LIMIT with mem_ready=0 SHALL go to FAULT; mem_ready=1 in the limit cycle completes normally.
REQ-017 FAULT SHALL be absorbing, fault=1, all strobes 0; only rst_n exits.

Reset
REQ-018 rst_n=0 SHALL immediately force state FETCH, wait counter 0, all strobes 0; FETCH strobes appear combinationally once rst_n deasserts.
REQ-019 Reset mid-MEM SHALL abandon the access; no ld_reg_file or mem_wr after rst_n falls.

Configuration
REQ-020 With CONTROL_COND_EN defined: cond 0 always; 1..4 pass if status[cond-1]=1; 5..8 pass if status[cond-5]=0; 9..15 never.
REQ-021 Without CONTROL_COND_EN: every condition passes; cond field ignored.

Structure
REQ-022 Package control_pkg SHALL hold state enum, opcode enum, cond enum and field-position constants.
REQ-023 Sub-module cond_check (cond, status -> pass) SHALL isolate REQ-020/021 logic.

Verification
REQ-024 Reset then ir=0x01000021, mem_ready=1 -> FETCH, DECODE, EXEC with sel_a=2, sel_b=1, ld_reg_file=1, back to FETCH in 3 cycles.
REQ-025 ir=0x02000034, mem_ready low 3 cycles in MEM -> mem_rd held 4 cycles; ld_reg_file=1 with sel_b=4 only in mem_ready cycle.
REQ-026 mem_ready stuck 0 in FETCH, WAIT_LIMIT=15 -> fault=1 after 15 cycles; stays until rst_n.
REQ-027 CONTROL_COND_EN, ir=0x11000021, status=0 -> DECODE returns to FETCH, no ld_reg_file; status=1 -> executes.
REQ-028 ir=0x0F000000 -> halted=1 indefinitely; ir=0x07000000 -> fault=1.
REQ-029 rst_n low during MEM store -> mem_wr drops same cycle; restart in FETCH.

Source files
------------

// File: rtl/control_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : control_pkg
//  Brief    : Shared types and instruction field positions for control_seq.
//             The condition check controlled by CONTROL_COND_EN uses cond_t.
//  Revision : 1.0  initial release
// ============================================================================
package control_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    // Opcodes carried in ir[27:24]; everything not listed is illegal
    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ALU  = 4'd1,
        OP_LD   = 4'd2,
        OP_ST   = 4'd3,
        OP_JMP  = 4'd4,
        OP_HALT = 4'd15
    } opcode_t;

    // Condition codes in ir[31:28]; status = {V,N,C,Z}
    typedef enum logic [3:0] {
        COND_AL = 4'd0,
        COND_ZS = 4'd1,
        COND_CS = 4'd2,
        COND_NS = 4'd3,
        COND_VS = 4'd4,
        COND_ZC = 4'd5,
        COND_CC = 4'd6,
        COND_NC = 4'd7,
        COND_VC = 4'd8
    } cond_t;

    // Instruction field positions
    localparam int c_COND_MSB   = 31;
    localparam int c_COND_LSB   = 28;
    localparam int c_OPC_MSB    = 27;
    localparam int c_OPC_LSB    = 24;
    localparam int c_ALUOP_MSB  = 23;
    localparam int c_ALUOP_LSB  = 20;

    // Wait counter width covers WAIT_LIMIT up to 255
    localparam int c_WAIT_CNT_W = 8;

endpackage : control_pkg
`default_nettype wire

// File: rtl/control_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : control_seq_if
//  Brief    : Instruction/status/memory-handshake inputs and datapath strobes
//             of the control sequencer. master = sequencer, slave = datapath.
//  Revision : 1.0  initial release
// ============================================================================
interface control_seq_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0] ir;
    logic [3:0]            status;
    logic                  mem_ready;
    logic                  mem_rd;
    logic                  mem_wr;
    logic                  oe_a_reg_file;
    logic                  oe_b_reg_file;
    logic                  ld_reg_file;
    logic [SEL_WIDTH-1:0]  sel_a_reg_file;
    logic [SEL_WIDTH-1:0]  sel_b_reg_file;
    logic                  ld_ir;
    logic                  ld_status;
    logic                  oe_mar;
    logic                  ld_mar;
    logic                  oe_b_pc;
    logic                  ld_pc;
    logic                  inc_pc;
    logic                  oe_alu;
    logic [3:0]            alu_op;
    logic                  halted;
    logic                  fault;

    modport master (
        input  ir, status, mem_ready,
        output mem_rd, mem_wr, oe_a_reg_file, oe_b_reg_file, ld_reg_file,
               sel_a_reg_file, sel_b_reg_file, ld_ir, ld_status, oe_mar,
               ld_mar, oe_b_pc, ld_pc, inc_pc, oe_alu, alu_op, halted, fault
    );

    modport slave (
        output ir, status, mem_ready,
        input  mem_rd, mem_wr, oe_a_reg_file, oe_b_reg_file, ld_reg_file,
               sel_a_reg_file, sel_b_reg_file, ld_ir, ld_status, oe_mar,
               ld_mar, oe_b_pc, ld_pc, inc_pc, oe_alu, alu_op, halted, fault
    );
endinterface : control_seq_if
`default_nettype wire

// File: rtl/control_seq_cond_check.sv
`default_nettype none
// ============================================================================
//  Module   : cond_check
//  Brief    : Evaluates the instruction condition field against status flags.
//             CONTROL_COND_EN defined : conditional execution enabled.
//             CONTROL_COND_EN undefined: every instruction executes.
//  Revision : 1.0  initial release
// ============================================================================
module cond_check
    import control_pkg::*;
(
    input  wire logic [3:0] cond_i,
    input  wire logic [3:0] status_i,
    output logic            pass_o
);

`ifdef CONTROL_COND_EN
    // 0 always, 1..4 flag set, 5..8 flag clear, 9..15 never
    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            COND_AL: pass_o = 1'b1;
            COND_ZS: pass_o = status_i[0];
            COND_CS: pass_o = status_i[1];
            COND_NS: pass_o = status_i[2];
            COND_VS: pass_o = status_i[3];
            COND_ZC: pass_o = ~status_i[0];
            COND_CC: pass_o = ~status_i[1];
            COND_NC: pass_o = ~status_i[2];
            COND_VC: pass_o = ~status_i[3];
            default: pass_o = 1'b0;
        endcase
    end
`else
    // Condition field is ignored in this build
    logic w_unused_cond;
    assign w_unused_cond = ^{cond_i, status_i};
    assign pass_o        = 1'b1;
`endif

endmodule : cond_check
`default_nettype wire

// File: rtl/control_seq.sv
`default_nettype none
// ============================================================================
//  Module   : control_seq
//  Brief    : Multi-cycle instruction control sequencer
//             (FETCH/DECODE/EXEC/MEM/HALT/FAULT) with memory-wait timeout.
//             Optional macro CONTROL_COND_EN enables conditional execution.
//  Revision : 1.0  initial release
// ============================================================================
module control_seq
    import control_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4,
    parameter int WAIT_LIMIT = 15
)(
    input  wire logic      clk,
    input  wire logic      rst_n,
    control_seq_if.master  ctrl_if
);

    localparam logic [c_WAIT_CNT_W-1:0] c_WAIT_LAST = c_WAIT_CNT_W'(WAIT_LIMIT - 1);

    state_t                  state_q, state_d;
    logic [c_WAIT_CNT_W-1:0] wait_q, wait_d;

    logic [3:0]           w_cond;
    logic [3:0]           w_opcode;
    logic [3:0]           w_alu_op;
    logic [SEL_WIDTH-1:0] w_sel_a;
    logic [SEL_WIDTH-1:0] w_sel_b;
    logic                 w_cond_pass;
    logic                 w_wait_expired;
    logic                 w_unused_ir;

    assign w_cond   = ctrl_if.ir[c_COND_MSB:c_COND_LSB];
    assign w_opcode = ctrl_if.ir[c_OPC_MSB:c_OPC_LSB];
    assign w_alu_op = ctrl_if.ir[c_ALUOP_MSB:c_ALUOP_LSB];
    assign w_sel_a  = ctrl_if.ir[2*SEL_WIDTH-1:SEL_WIDTH];
    assign w_sel_b  = ctrl_if.ir[SEL_WIDTH-1:0];

    // Bits between the select fields and alu_op are reserved
    assign w_unused_ir = ^ctrl_if.ir;

    // This cycle is the last one allowed to stall on mem_ready
    assign w_wait_expired = (wait_q == c_WAIT_LAST);

    cond_check u_cond_check (
        .cond_i   (w_cond),
        .status_i (ctrl_if.status),
        .pass_o   (w_cond_pass)
    );

    // State and wait-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state and wait-counter update
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (ctrl_if.mem_ready)  state_d = ST_DECODE;
                else if (w_wait_expired) state_d = ST_FAULT;
            end
            ST_DECODE: state_d = w_cond_pass ? ST_EXEC : ST_FETCH;
            ST_EXEC: begin
                case (w_opcode)
                    OP_NOP, OP_ALU, OP_JMP: state_d = ST_FETCH;
                    OP_LD, OP_ST:           state_d = ST_MEM;
                    OP_HALT:                state_d = ST_HALT;
                    default:                state_d = ST_FAULT;
                endcase
            end
            ST_MEM: begin
                if (ctrl_if.mem_ready)  state_d = ST_FETCH;
                else if (w_wait_expired) state_d = ST_FAULT;
            end
            ST_HALT:  state_d = ST_HALT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase

        // Any state change restarts the count, so entry to FETCH/MEM sees 0
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (((state_q == ST_FETCH) || (state_q == ST_MEM)) && !ctrl_if.mem_ready) begin
            wait_d = wait_q + 1'b1;
        end
    end

    logic                 w_mem_rd, w_mem_wr;
    logic                 w_oe_a, w_oe_b, w_ld_rf;
    logic [SEL_WIDTH-1:0] w_sel_a_out, w_sel_b_out;
    logic                 w_ld_ir, w_ld_status, w_oe_mar, w_ld_mar;
    logic                 w_oe_b_pc, w_ld_pc, w_inc_pc, w_oe_alu;
    logic [3:0]           w_alu_op_out;
    logic                 w_halted, w_fault;

    // Strobe decode from current state, instruction and mem_ready
    always_comb begin
        w_mem_rd     = 1'b0;
        w_mem_wr     = 1'b0;
        w_oe_a       = 1'b0;
        w_oe_b       = 1'b0;
        w_ld_rf      = 1'b0;
        w_sel_a_out  = '0;
        w_sel_b_out  = '0;
        w_ld_ir      = 1'b0;
        w_ld_status  = 1'b0;
        w_oe_mar     = 1'b0;
        w_ld_mar     = 1'b0;
        w_oe_b_pc    = 1'b0;
        w_ld_pc      = 1'b0;
        w_inc_pc     = 1'b0;
        w_oe_alu     = 1'b0;
        w_alu_op_out = '0;
        w_halted     = 1'b0;
        w_fault      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                w_oe_b_pc = 1'b1;
                w_mem_rd  = 1'b1;
                if (ctrl_if.mem_ready) begin
                    w_ld_ir  = 1'b1;
                    w_inc_pc = 1'b1;
                end
            end
            ST_EXEC: begin
                case (w_opcode)
                    OP_ALU: begin
                        w_oe_a       = 1'b1;
                        w_oe_b       = 1'b1;
                        w_oe_alu     = 1'b1;
                        w_ld_rf      = 1'b1;
                        w_ld_status  = 1'b1;
                        w_sel_a_out  = w_sel_a;
                        w_sel_b_out  = w_sel_b;
                        w_alu_op_out = w_alu_op;
                    end
                    OP_LD, OP_ST: begin
                        w_oe_a      = 1'b1;
                        w_ld_mar    = 1'b1;
                        w_sel_a_out = w_sel_a;
                    end
                    OP_JMP: begin
                        w_oe_a  = 1'b1;
                        w_ld_pc = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                w_oe_mar = 1'b1;
                if (w_opcode == OP_ST) begin
                    w_mem_wr = 1'b1;
                    w_oe_b   = 1'b1;
                end else begin
                    w_mem_rd = 1'b1;
                    if (ctrl_if.mem_ready) begin
                        w_ld_rf     = 1'b1;
                        w_sel_b_out = w_sel_b;
                    end
                end
            end
            ST_HALT:  w_halted = 1'b1;
            ST_FAULT: w_fault  = 1'b1;
            default: ;
        endcase
    end

    // Reset masks every output immediately, abandoning any access in flight
    assign ctrl_if.mem_rd         = w_mem_rd    & rst_n;
    assign ctrl_if.mem_wr         = w_mem_wr    & rst_n;
    assign ctrl_if.oe_a_reg_file  = w_oe_a      & rst_n;
    assign ctrl_if.oe_b_reg_file  = w_oe_b      & rst_n;
    assign ctrl_if.ld_reg_file    = w_ld_rf     & rst_n;
    assign ctrl_if.sel_a_reg_file = rst_n ? w_sel_a_out : '0;
    assign ctrl_if.sel_b_reg_file = rst_n ? w_sel_b_out : '0;
    assign ctrl_if.ld_ir          = w_ld_ir     & rst_n;
    assign ctrl_if.ld_status      = w_ld_status & rst_n;
    assign ctrl_if.oe_mar         = w_oe_mar    & rst_n;
    assign ctrl_if.ld_mar         = w_ld_mar    & rst_n;
    assign ctrl_if.oe_b_pc        = w_oe_b_pc   & rst_n;
    assign ctrl_if.ld_pc          = w_ld_pc     & rst_n;
    assign ctrl_if.inc_pc         = w_inc_pc    & rst_n;
    assign ctrl_if.oe_alu         = w_oe_alu    & rst_n;
    assign ctrl_if.alu_op         = rst_n ? w_alu_op_out : 4'd0;
    assign ctrl_if.halted         = w_halted    & rst_n;
    assign ctrl_if.fault          = w_fault     & rst_n;

endmodule : control_seq
`default_nettype wire
